univ_shift_reg: RTL and testbench

Parametrised universal register, the successor to the single-bit D flip-flop. It extends that cell to a WIDTH-bit register with clock enable, parallel load, shift, rotate and clear modes, plus serial in/out. A shift counter with a done pulse lets the block act directly as a serializer or deserializer in lab datapaths.

---
 rtl/univ_shift_reg.sv | 107 ++++++++++
 tb/tb_univ_shift_reg.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold, shift, rotate, load and clear modes with serial I/O.
// A shift counter wraps every WIDTH shifts/rotates and pulses done for serializer use.
module univ_shift_reg #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [2:0]        mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin_l,
  input  logic              sin_r,
  output logic [WIDTH-1:0]  q,
  output logic              sout_l,
  output logic              sout_r,
  output logic [CNT_W-1:0]  cnt,
  output logic              done
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_LOAD  = 3'b011,
    MODE_ROTL  = 3'b100,
    MODE_ROTR  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             is_shift;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);

  always_comb begin
    data_d   = data_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    is_shift = 1'b0;
    if (en) begin
      done_d = 1'b0;
      case (mode_sel)
        MODE_SHL: begin
          data_d   = {data_q[WIDTH-2:0], sin_r};
          is_shift = 1'b1;
        end
        MODE_SHR: begin
          data_d   = {sin_l, data_q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        MODE_LOAD: begin
          data_d = d;
          cnt_d  = '0;
        end
        MODE_ROTL: begin
          data_d   = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
          is_shift = 1'b1;
        end
        MODE_ROTR: begin
          data_d   = {data_q[0], data_q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        MODE_CLEAR: begin
          data_d = '0;
          cnt_d  = '0;
        end
        default: ;
      endcase
      // Wrap after the WIDTH-th shift; done rises on the same edge.
      if (is_shift) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q      = data_q;
  assign sout_l = data_q[WIDTH-1];
  assign sout_r = data_q[0];
  assign cnt    = cnt_q;
  assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: two instances (RESET_VAL 0x00 and 0xC3) share stimulus and are
// compared every cycle against a shift-count model; directed literals pin the model.
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic          sin_l, sin_r;

  logic [W-1:0]  q0, q1;
  logic          sl0, sr0, sl1, sr1;
  logic [CW-1:0] cnt0, cnt1;
  logic          done0, done1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .q(q0), .sout_l(sl0), .sout_r(sr0),
    .cnt(cnt0), .done(done0)
  );

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'hC3)) dut_c3 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .q(q1), .sout_l(sl1), .sout_r(sr1),
    .cnt(cnt1), .done(done1)
  );

  // Model: register value per instance, and total shifts since last load/clear/reset.
  logic [W-1:0] m_q [2];
  int           m_n;
  logic         m_done;

  function automatic logic [W-1:0] next_val(input logic [W-1:0] v, input logic [2:0] m,
                                            input logic [W-1:0] dd, input logic sl,
                                            input logic sr);
    int x;
    x = int'(v);
    case (m)
      3'd1:    return W'((x * 2) + int'(sr));
      3'd2:    return W'((x / 2) + (int'(sl) << (W - 1)));
      3'd3:    return dd;
      3'd4:    return W'((x * 2) + (x / (1 << (W - 1))));
      3'd5:    return W'((x / 2) + ((x % 2) << (W - 1)));
      3'd6:    return '0;
      default: return v;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q[0] <= 8'h00;
      m_q[1] <= 8'hC3;
      m_n    <= 0;
      m_done <= 1'b0;
    end else if (en) begin
      m_q[0] <= next_val(m_q[0], mode, d, sin_l, sin_r);
      m_q[1] <= next_val(m_q[1], mode, d, sin_l, sin_r);
      if (mode inside {3'd1, 3'd2, 3'd4, 3'd5}) begin
        m_n    <= m_n + 1;
        m_done <= ((m_n + 1) % W) == 0;
      end else if (mode inside {3'd3, 3'd6}) begin
        m_n    <= 0;
        m_done <= 1'b0;
      end else begin
        m_done <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("q0",     32'(q0),    32'(m_q[0]));
    check("q1",     32'(q1),    32'(m_q[1]));
    check("cnt0",   32'(cnt0),  32'(m_n % W));
    check("cnt1",   32'(cnt1),  32'(m_n % W));
    check("done0",  32'(done0), 32'(m_done));
    check("done1",  32'(done1), 32'(m_done));
    check("sout_l", 32'(sl0),   32'(m_q[0][W-1]));
    check("sout_r", 32'(sr0),   32'(m_q[0][0]));
  end

  // Apply one set of inputs just after a falling edge, return at the next falling edge.
  task automatic step(input logic [2:0] m, input logic [W-1:0] dd = '0,
                      input logic sl = 1'b0, input logic sr = 1'b0, input logic e = 1'b1);
    mode = m; d = dd; sin_l = sl; sin_r = sr; en = e;
    @(negedge clk);
  endtask

  task automatic mid_cycle_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_q0",   32'(q0),    32'h00);
    check("rst_q1",   32'(q1),    32'hC3);
    check("rst_cnt",  32'(cnt0),  32'd0);
    check("rst_done", 32'(done0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = '0; d = '0; sin_l = 1'b0; sin_r = 1'b0;
    @(negedge clk); @(negedge clk);
    check("init_q1", 32'(q1), 32'hC3);
    reset = 1'b0;

    // 1. async reset between edges
    step(3'd3, 8'h5A);
    check("ld5a", 32'(q0), 32'h5A);
    mid_cycle_reset();

    // 2. load and shift
    step(3'd3, 8'hA5);
    check("ld_q", 32'(q0), 32'hA5); check("ld_cnt", 32'(cnt0), 0);
    step(3'd1, '0, 1'b0, 1'b1);
    check("shl_q", 32'(q0), 32'h4B); check("shl_cnt", 32'(cnt0), 1);
    step(3'd2, '0, 1'b0, 1'b0);
    check("shr_q", 32'(q0), 32'h25); check("shr_cnt", 32'(cnt0), 2);
    check("shr_sr", 32'(sr0), 1);

    // 3. rotate
    step(3'd3, 8'h81);
    step(3'd4);
    check("rotl_q", 32'(q0), 32'h03);
    step(3'd5); step(3'd5);
    check("rotr_q", 32'(q0), 32'hC0); check("rotr_sl", 32'(sl0), 1);
    check("rotr_cnt", 32'(cnt0), 3);

    // 4. wrap
    step(3'd3, 8'h96);
    for (int i = 0; i < 7; i++) begin
      step(3'd4);
      check("pre_wrap_done", 32'(done0), 0);
    end
    step(3'd4);
    check("wrap_q", 32'(q0), 32'h96); check("wrap_cnt", 32'(cnt0), 0);
    check("wrap_done", 32'(done0), 1);
    step(3'd0, '0, 1'b0, 1'b0, 1'b0);
    check("done_stall", 32'(done0), 1);
    step(3'd4);
    check("nine_cnt", 32'(cnt0), 1); check("nine_done", 32'(done0), 0);

    // 5. enable, reserved, clear
    step(3'd3, 8'h3C);
    for (int i = 0; i < 3; i++) step(3'd1);
    check("3shl_q", 32'(q0), 32'hE0);
    for (int i = 0; i < 4; i++) begin
      step(3'(i + 1), 8'(i * 37), 1'b1, 1'b1, 1'b0);
      check("en0_q", 32'(q0), 32'hE0); check("en0_cnt", 32'(cnt0), 3);
    end
    step(3'd7, 8'hFF, 1'b1, 1'b1);
    check("rsvd_q", 32'(q0), 32'hE0); check("rsvd_cnt", 32'(cnt0), 3);
    step(3'd6);
    check("clr_q", 32'(q0), 32'h00); check("clr_cnt", 32'(cnt0), 0);

    // 6. reset mid-serialization
    step(3'd3, 8'h55);
    for (int i = 0; i < 5; i++) step(3'd1, '0, 1'b0, 1'b1);
    mid_cycle_reset();
    for (int i = 0; i < 8; i++) begin
      step(3'd1, '0, 1'b0, 1'(i));
      check("ser_done", 32'(done0), (i == 7) ? 1 : 0);
    end

    // random phase
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) mid_cycle_reset();
      else step(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
